// File: rtl/alarm_snooze_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_snooze_ctrl
//   Buzzer, snooze and stop control downstream of the alarm-compare block.
//   A single three-state FSM (IDLE / RING / SNOOZE) owns the two seconds
//   timers, the beep phase and the snooze counter. Every output is a flop
//   loaded from the next-state logic, so an output changes on the same clock
//   edge that samples the input causing the change. No combinational path
//   runs from an input to an output.
// -----------------------------------------------------------------------------
module alarm_snooze_ctrl #(
  parameter int unsigned SNOOZE_SEC       = 300,  // 1..65535
  parameter int unsigned RING_TIMEOUT_SEC = 60,   // 1..65535
  parameter int unsigned MAX_SNOOZE       = 3     // 0..15
) (
  input  logic       clk,
  input  logic       clr,          // asynchronous, active-low
  input  logic       enable,
  input  logic       tick_1hz,
  input  logic       alarm_in,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_cnt,
  output logic       timeout_evt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  // Last timer value before expiry. A timer never goes past this value
  // because the state change on expiry reloads it.
  localparam logic [15:0] RING_LAST   = 16'(RING_TIMEOUT_SEC - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
  localparam logic [3:0]  SNOOZE_MAX  = 4'(MAX_SNOOZE);

  // State and internal registers
  state_e      state_q,      state_d;
  logic [15:0] ring_timer_q, ring_timer_d;
  logic [15:0] snz_timer_q,  snz_timer_d;
  logic        beep_q,       beep_d;
  logic [3:0]  snooze_cnt_q, snooze_cnt_d;
  logic        alarm_prev_q;

  // Registered outputs
  logic        buzzer_q,      buzzer_d;
  logic        ringing_q,     ringing_d;
  logic        snoozing_q,    snoozing_d;
  logic        timeout_evt_q, timeout_evt_d;

  // A level that is already high when reset releases counts as a rise,
  // because alarm_prev comes out of reset at 0.
  logic alarm_rise;
  assign alarm_rise = alarm_in & ~alarm_prev_q;

  // A snooze request is only honoured while snoozes remain.
  logic snooze_ok;
  assign snooze_ok = snooze_btn & (snooze_cnt_q < SNOOZE_MAX);

  // Next-state, timer, counter and output decode.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through the block leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    ring_timer_d  = ring_timer_q;
    snz_timer_d   = snz_timer_q;
    beep_d        = beep_q;
    snooze_cnt_d  = snooze_cnt_q;
    timeout_evt_d = 1'b0;

    if (!enable) begin
      // Disarming overrides any event in the same cycle.
      state_d      = ST_IDLE;
      snooze_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_rise) begin
            state_d      = ST_RING;
            ring_timer_d = 16'd0;
            snz_timer_d  = 16'd0;
            beep_d       = 1'b1;
            snooze_cnt_d = 4'd0;
          end
        end

        ST_RING: begin
          // Priority: stop, then snooze, then timeout. A snooze refused at
          // the limit falls through, so that cycle's tick still counts.
          if (stop_btn) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = 4'd0;
          end else if (snooze_ok) begin
            state_d      = ST_SNOOZE;
            snz_timer_d  = 16'd0;
            snooze_cnt_d = snooze_cnt_q + 4'd1;
          end else if (tick_1hz) begin
            if (ring_timer_q == RING_LAST) begin
              state_d       = ST_IDLE;
              timeout_evt_d = 1'b1;
              snooze_cnt_d  = 4'd0;
            end else begin
              beep_d       = ~beep_q;
              ring_timer_d = ring_timer_q + 16'd1;
            end
          end
        end

        ST_SNOOZE: begin
          // Snooze presses and new alarm rises mean nothing here. A stop
          // press beats a snooze expiry in the same cycle.
          if (stop_btn) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = 4'd0;
          end else if (tick_1hz) begin
            if (snz_timer_q == SNOOZE_LAST) begin
              state_d      = ST_RING;
              ring_timer_d = 16'd0;
              beep_d       = 1'b1;
            end else begin
              snz_timer_d = snz_timer_q + 16'd1;
            end
          end
        end

        default: begin
          state_d      = ST_IDLE;
          snooze_cnt_d = 4'd0;
        end
      endcase
    end

    // The outputs are decoded from the next state, so the output flops
    // show the new state on the same edge that loads the state register.
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
    buzzer_d   = (state_d == ST_RING) & beep_d;
  end

  // State, timers, edge-detect history and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= ST_IDLE;
      ring_timer_q  <= 16'd0;
      snz_timer_q   <= 16'd0;
      beep_q        <= 1'b0;
      snooze_cnt_q  <= 4'd0;
      alarm_prev_q  <= 1'b0;
      buzzer_q      <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge no matter how the statements are ordered.
      state_q       <= state_d;
      ring_timer_q  <= ring_timer_d;
      snz_timer_q   <= snz_timer_d;
      beep_q        <= beep_d;
      snooze_cnt_q  <= snooze_cnt_d;
      alarm_prev_q  <= alarm_in;
      buzzer_q      <= buzzer_d;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = ringing_q;
  assign snoozing    = snoozing_q;
  assign snooze_cnt  = snooze_cnt_q;
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_snooze_ctrl
//   Directed bench. The stimulus process drives one clock at a time. After
//   each step of interest it pushes a hand-computed output snapshot into a
//   queue. A separate monitor pops the queue on each falling edge and compares
//   the snapshot against the DUT outputs.
//   Snapshot bit layout: {buzzer, ringing, snoozing, snooze_cnt[3:0], timeout_evt}
// -----------------------------------------------------------------------------
module tb_alarm_snooze_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic       tick_1hz;
  logic       alarm_in;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_cnt;
  logic       timeout_evt;

  alarm_snooze_ctrl #(
    .SNOOZE_SEC      (5),
    .RING_TIMEOUT_SEC(4),
    .MAX_SNOOZE      (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .enable     (enable),
    .tick_1hz   (tick_1hz),
    .alarm_in   (alarm_in),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {bz,rg,sz,cnt,te}=%b_%b_%b_%h_%b want %b_%b_%b_%h_%b",
               nm, got[7], got[6], got[5], got[4:1], got[0],
               want[7], want[6], want[5], want[4:1], want[0]);
    end
  endtask

  // Monitor: compares every pending expectation against the outputs,
  // half a cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.nm, {buzzer, ringing, snoozing, snooze_cnt, timeout_evt}, e.v);
      end
    end
  end

  // Push one expected output snapshot.
  task automatic expect_o(input string nm, input logic bz, input logic rg,
                          input logic sz, input logic [3:0] cnt, input logic te);
    exp_t e;
    e.nm = nm;
    e.v  = {bz, rg, sz, cnt, te};
    exp_q.push_back(e);
  endtask

  // Apply one clock of inputs. Pulses last for exactly this clock.
  task automatic drive(input logic t, input logic sn, input logic sp, input logic al);
    tick_1hz   = t;
    snooze_btn = sn;
    stop_btn   = sp;
    alarm_in   = al;
    @(posedge clk);
    #1;
    tick_1hz   = 1'b0;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    alarm_in   = 1'b0;
  endtask

  // One second: nine quiet clocks, then a tick clock carrying optional buttons.
  task automatic second(input logic sn, input logic sp);
    repeat (9) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, sn, sp, 1'b0);
  endtask

  initial begin
    clr = 1'b0; enable = 1'b1; tick_1hz = 1'b0;
    alarm_in = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_o("reset_state", 0, 0, 0, 4'd0, 0);
    clr = 1'b1;
    drive(0, 0, 0, 0);
    expect_o("idle_after_reset", 0, 0, 0, 4'd0, 0);

    // ---- ring and timeout ----
    drive(0, 0, 0, 1);
    expect_o("ring_start", 1, 1, 0, 4'd0, 0);
    second(0, 0); expect_o("ring_tick1", 0, 1, 0, 4'd0, 0);
    second(0, 0); expect_o("ring_tick2", 1, 1, 0, 4'd0, 0);
    second(0, 0); expect_o("ring_tick3", 0, 1, 0, 4'd0, 0);
    second(0, 0); expect_o("timeout_tick4", 0, 0, 0, 4'd0, 1);
    drive(0, 0, 0, 0);
    expect_o("timeout_pulse_end", 0, 0, 0, 4'd0, 0);

    // ---- snooze cycle ----
    drive(0, 0, 0, 1);
    expect_o("ring2_start", 1, 1, 0, 4'd0, 0);
    drive(0, 1, 0, 0);
    expect_o("snooze1", 0, 0, 1, 4'd1, 0);
    repeat (4) second(0, 0);
    expect_o("snooze1_tick4", 0, 0, 1, 4'd1, 0);
    second(0, 0);
    expect_o("rering1", 1, 1, 0, 4'd1, 0);

    // ---- snooze limit ----
    drive(0, 1, 0, 0);
    expect_o("snooze2", 0, 0, 1, 4'd2, 0);
    repeat (5) second(0, 0);
    expect_o("rering2", 1, 1, 0, 4'd2, 0);
    drive(0, 1, 0, 0);
    expect_o("snooze_at_limit", 1, 1, 0, 4'd2, 0);
    drive(0, 0, 1, 0);
    expect_o("stop_clears", 0, 0, 0, 4'd0, 0);

    // ---- stop and snooze together in RING ----
    drive(0, 0, 0, 1);
    expect_o("ring3_start", 1, 1, 0, 4'd0, 0);
    drive(0, 1, 1, 0);
    expect_o("stop_beats_snooze", 0, 0, 0, 4'd0, 0);

    // ---- stop on the snooze expiry tick ----
    drive(0, 0, 0, 1);
    expect_o("ring4_start", 1, 1, 0, 4'd0, 0);
    drive(0, 1, 0, 0);
    expect_o("snooze4", 0, 0, 1, 4'd1, 0);
    repeat (4) second(0, 0);
    second(0, 1);
    expect_o("stop_beats_expiry", 0, 0, 0, 4'd0, 0);

    // ---- snooze on the timeout tick ----
    drive(0, 0, 0, 1);
    expect_o("ring5_start", 1, 1, 0, 4'd0, 0);
    repeat (3) second(0, 0);
    expect_o("ring5_tick3", 0, 1, 0, 4'd0, 0);
    second(1, 0);
    expect_o("snooze_beats_timeout", 0, 0, 1, 4'd1, 0);
    drive(0, 0, 0, 0);
    expect_o("no_late_timeout", 0, 0, 1, 4'd1, 0);

    // ---- enable drop while snoozing ----
    enable = 1'b0;
    drive(0, 0, 0, 0);
    expect_o("disable_in_snooze", 0, 0, 0, 4'd0, 0);
    drive(0, 0, 0, 1);
    expect_o("alarm_while_disabled", 0, 0, 0, 4'd0, 0);
    enable = 1'b1;
    drive(0, 0, 0, 0);
    expect_o("no_ring_after_enable", 0, 0, 0, 4'd0, 0);

    // ---- fresh event, then asynchronous reset in the middle of RING ----
    drive(0, 0, 0, 1);
    expect_o("fresh_event", 1, 1, 0, 4'd0, 0);
    second(0, 0);
    expect_o("fresh_tick1", 0, 1, 0, 4'd0, 0);
    second(0, 0);
    clr = 1'b0;
    #1;
    expect_o("async_reset", 0, 0, 0, 4'd0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    clr = 1'b1;
    repeat (3) drive(0, 0, 0, 0);
    expect_o("idle_after_rerelease", 0, 0, 0, 4'd0, 0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations still queued, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
